// File: rtl/quant_wr_merge_4to1_pkg.sv
// Shared types and constants for the 4-to-1 quantise write merger.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package quant_wr_merge_4to1_pkg;

  localparam int NUM_STREAMS  = 4;
  localparam int PKG_UNIT_NUM = 16;
  localparam int PKG_OUT_BITS = 8;
  localparam int PKG_ADDR_W   = 16;
  localparam int PKG_DATA_W   = PKG_UNIT_NUM * PKG_OUT_BITS;
  localparam int BEAT_W       = PKG_ADDR_W + PKG_DATA_W;

  // Round-robin pointer over the four streams; wraps naturally at 2 bits.
  typedef logic [1:0] rr_ptr_t;

  // One SRAM write beat as it travels through the FIFOs and output register.
  typedef struct packed {
    logic [PKG_ADDR_W-1:0] addr;
    logic [PKG_DATA_W-1:0] data;
  } beat_t;

  // Pointer value that follows a grant to stream k.
  function automatic rr_ptr_t rr_next(input rr_ptr_t k);
    return k + rr_ptr_t'(1);
  endfunction

endpackage

// File: rtl/wr_beat_fifo.sv
// Small synchronous FIFO holding write beats for one input stream.
// Latency: a push is visible at head/!empty the cycle after the edge.
// Backpressure: none upstream; a push while full is ignored unless a pop happens in the same cycle.
module wr_beat_fifo
  import quant_wr_merge_4to1_pkg::*;
#(
  parameter int WIDTH = BEAT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a beat when its head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Pointer and occupancy tracking; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Beat storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/quant_wr_merge_4to1.sv
// Merges four non-stallable write streams onto one SRAM write port, round-robin.
// Latency: 2 cycles from wr_enN to mem_wr_en when the FIFO and output register are idle.
// Backpressure: mem_ready low holds the output beat; inputs are buffered, dropped beats flag overflow.
module quant_wr_merge_4to1
  import quant_wr_merge_4to1_pkg::*;
#(
  parameter int UNIT_NUM   = PKG_UNIT_NUM,
  parameter int OUT_BITS   = PKG_OUT_BITS,
  parameter int ADDR_W     = PKG_ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en0,
  input  logic                         wr_en1,
  input  logic                         wr_en2,
  input  logic                         wr_en3,
  input  logic [ADDR_W-1:0]            wr_addr0,
  input  logic [ADDR_W-1:0]            wr_addr1,
  input  logic [ADDR_W-1:0]            wr_addr2,
  input  logic [ADDR_W-1:0]            wr_addr3,
  input  logic [UNIT_NUM*OUT_BITS-1:0] wr_data0,
  input  logic [UNIT_NUM*OUT_BITS-1:0] wr_data1,
  input  logic [UNIT_NUM*OUT_BITS-1:0] wr_data2,
  input  logic [UNIT_NUM*OUT_BITS-1:0] wr_data3,
  input  logic                         start,
  input  logic [15:0]                  cfg_expected_writes,
  input  logic                         mem_ready,
  output logic                         mem_wr_en,
  output logic [ADDR_W-1:0]            mem_wr_addr,
  output logic [UNIT_NUM*OUT_BITS-1:0] mem_wr_data,
  output logic                         done,
  output logic                         busy,
  output logic [3:0]                   overflow,
  output logic [15:0]                  write_count
);

  logic [NUM_STREAMS-1:0] in_en;
  beat_t                  in_beat    [NUM_STREAMS];
  beat_t                  fifo_head  [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] fifo_full;
  logic [NUM_STREAMS-1:0] fifo_empty;
  logic [NUM_STREAMS-1:0] fifo_pop;
  logic [NUM_STREAMS-1:0] drop;

  rr_ptr_t rr_ptr;
  rr_ptr_t grant;
  logic    any_ne;
  logic    load;
  logic    handshake;
  beat_t   out_beat;
  logic [15:0] next_count;

  assign in_en      = {wr_en3, wr_en2, wr_en1, wr_en0};
  assign in_beat[0] = {wr_addr0, wr_data0};
  assign in_beat[1] = {wr_addr1, wr_data1};
  assign in_beat[2] = {wr_addr2, wr_data2};
  assign in_beat[3] = {wr_addr3, wr_data3};

  for (genvar s = 0; s < NUM_STREAMS; s++) begin : g_fifo
    wr_beat_fifo #(
      .WIDTH (BEAT_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (in_en[s]),
      .din   (in_beat[s]),
      .pop   (fifo_pop[s]),
      .full  (fifo_full[s]),
      .empty (fifo_empty[s]),
      .head  (fifo_head[s])
    );
  end

  // Output register can take a new beat when empty or when its beat is being accepted.
  assign load      = !mem_wr_en || mem_ready;
  assign handshake = mem_wr_en && mem_ready;
  assign busy      = !(&fifo_empty) || mem_wr_en;
  assign next_count = write_count + 16'd1;

  // Round-robin search for the first non-empty FIFO starting at rr_ptr.
  always_comb begin
    rr_ptr_t idx;
    idx    = '0;
    grant  = '0;
    any_ne = 1'b0;
    for (int i = 0; i < NUM_STREAMS; i++) begin
      idx = rr_ptr + rr_ptr_t'(i);
      if (!any_ne && !fifo_empty[idx]) begin
        any_ne = 1'b1;
        grant  = idx;
      end
    end
  end

  // Pop the granted FIFO on load; flag beats that find their FIFO full and not draining.
  always_comb begin
    fifo_pop = '0;
    drop     = '0;
    for (int k = 0; k < NUM_STREAMS; k++) begin
      fifo_pop[k] = load && any_ne && (grant == rr_ptr_t'(k));
      drop[k]     = in_en[k] && fifo_full[k] && !fifo_pop[k];
    end
  end

  // Output beat register and arbitration pointer; holds steady while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en <= 1'b0;
      out_beat  <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      if (any_ne) begin
        mem_wr_en <= 1'b1;
        out_beat  <= fifo_head[grant];
        rr_ptr    <= rr_next(grant);
      end else begin
        mem_wr_en <= 1'b0;
      end
    end
  end

  assign mem_wr_addr = out_beat.addr;
  assign mem_wr_data = out_beat.data;

  // Layer bookkeeping: committed-write count, done pulse and sticky drop flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_count <= '0;
      done        <= 1'b0;
      overflow    <= '0;
    end else begin
      // A drop coinciding with start belongs to the new layer, so it is kept.
      overflow <= (start ? 4'b0000 : overflow) | drop;
      if (start) begin
        write_count <= '0;
        done        <= 1'b0;
      end else if (handshake) begin
        write_count <= next_count;
        done        <= (cfg_expected_writes != 16'd0) && (next_count == cfg_expected_writes);
      end else begin
        done <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quant_wr_merge_4to1.sv
// Self-checking bench: reference model feeds a beat scoreboard, plus directed checks.
module tb_quant_wr_merge_4to1;
  import quant_wr_merge_4to1_pkg::*;

  localparam int DEPTH = 4;

  logic         clk;
  logic         rst_n;
  logic [3:0]   en;
  logic [15:0]  addr_a [4];
  logic [127:0] data_a [4];
  logic         start;
  logic [15:0]  cfg;
  logic         mem_ready;
  logic         mem_wr_en;
  logic [15:0]  mem_wr_addr;
  logic [127:0] mem_wr_data;
  logic         done;
  logic         busy;
  logic [3:0]   overflow;
  logic [15:0]  write_count;

  int compared   = 0;
  int mismatched = 0;

  quant_wr_merge_4to1 dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .wr_en0              (en[0]),
    .wr_en1              (en[1]),
    .wr_en2              (en[2]),
    .wr_en3              (en[3]),
    .wr_addr0            (addr_a[0]),
    .wr_addr1            (addr_a[1]),
    .wr_addr2            (addr_a[2]),
    .wr_addr3            (addr_a[3]),
    .wr_data0            (data_a[0]),
    .wr_data1            (data_a[1]),
    .wr_data2            (data_a[2]),
    .wr_data3            (data_a[3]),
    .start               (start),
    .cfg_expected_writes (cfg),
    .mem_ready           (mem_ready),
    .mem_wr_en           (mem_wr_en),
    .mem_wr_addr         (mem_wr_addr),
    .mem_wr_data         (mem_wr_data),
    .done                (done),
    .busy                (busy),
    .overflow            (overflow),
    .write_count         (write_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (behavioural queues) ----------------
  beat_t       mq [4][$];
  beat_t       sb [$];
  logic [15:0] hs_log [$];
  bit          m_vld;
  int          m_rr;
  logic [15:0] m_cnt;
  bit          m_done;
  logic [3:0]  m_ovf;
  int          done_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
      sb.delete();
      m_vld = 0; m_rr = 0; m_cnt = 0; m_done = 0; m_ovf = 0;
    end else begin : model_step
      bit ld;
      bit hs;
      int g;
      beat_t b;
      logic [3:0] nov;
      hs = m_vld && mem_ready;
      ld = !m_vld || mem_ready;
      g  = -1;
      if (ld)
        for (int i = 0; i < 4; i++)
          if (g < 0 && mq[(m_rr + i) % 4].size() > 0) g = (m_rr + i) % 4;
      if (start) begin
        m_cnt = 0; m_done = 0;
      end else if (hs) begin
        m_cnt  = m_cnt + 16'd1;
        m_done = (cfg != 0) && (m_cnt == cfg);
      end else begin
        m_done = 0;
      end
      nov = start ? 4'b0000 : m_ovf;
      if (ld) begin
        if (g >= 0) begin
          b = mq[g].pop_front();
          sb.push_back(b);
          m_vld = 1;
          m_rr  = (g + 1) % 4;
        end else begin
          m_vld = 0;
        end
      end
      for (int n = 0; n < 4; n++) begin
        if (en[n]) begin
          b.addr = addr_a[n];
          b.data = data_a[n];
          if (mq[n].size() < DEPTH) mq[n].push_back(b);
          else nov[n] = 1'b1;
        end
      end
      m_ovf = nov;
    end
  end

  // Monitor on the falling edge: status vs model, accepted beats vs scoreboard.
  always @(negedge clk) begin : monitor
    beat_t eb;
    bit    mb;
    mb = m_vld;
    for (int i = 0; i < 4; i++) if (mq[i].size() > 0) mb = 1;
    check("mem_wr_en", mem_wr_en, m_vld);
    check("busy", busy, mb);
    check("overflow", overflow, m_ovf);
    check("write_count", write_count, m_cnt);
    check("done", done, m_done);
    if (mem_wr_en && mem_ready) begin
      check("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        eb = sb.pop_front();
        check("beat_addr", mem_wr_addr, eb.addr);
        check("beat_data", mem_wr_data, eb.data);
      end
      hs_log.push_back(mem_wr_addr);
    end
    if (done) done_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input int n, input logic [15:0] a, input logic [127:0] d);
    en[n]     = 1'b1;
    addr_a[n] = a;
    data_a[n] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  int s0_cnt;
  int s3_cnt;

  initial begin
    rst_n = 1'b1; en = '0; start = 0; cfg = 0; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin addr_a[i] = '0; data_a[i] = '0; end
    done_cnt = 0;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    // Reset state
    check("rst_mem_wr_en", mem_wr_en, 0);
    check("rst_addr", mem_wr_addr, 0);
    check("rst_data", mem_wr_data, 0);
    check("rst_busy", busy, 0);
    check("rst_overflow", overflow, 0);
    check("rst_count", write_count, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    // Single beat, 2-cycle latency
    drive(2, 16'h0010, {16{8'hA5}});
    tick(); en = '0;
    check("lat_t1_en", mem_wr_en, 0);
    tick();
    check("lat_t2_en", mem_wr_en, 1);
    check("lat_t2_addr", mem_wr_addr, 16'h0010);
    check("lat_t2_data", mem_wr_data, {16{8'hA5}});
    tick();
    check("single_count", write_count, 1);

    // Simultaneous pushes on all four streams
    do_reset();
    for (int i = 0; i < 4; i++) drive(i, 16'(i), {16{8'(8'h10 + i)}});
    tick(); en = '0;
    for (int j = 0; j < 4; j++) begin
      tick();
      check("simul_en", mem_wr_en, 1);
      check("simul_addr", mem_wr_addr, 16'(j));
    end
    tick();
    check("simul_busy_end", busy, 0);
    check("simul_en_end", mem_wr_en, 0);

    // Fairness between streams 0 and 3 with alternating ready
    do_reset();
    hs_log.delete();
    for (int i = 0; i < 8; i++) begin
      drive(0, 16'(16'h0100 + i), {16{8'(i)}});
      drive(3, 16'(16'h0300 + i), {16{8'(8'h80 + i)}});
      mem_ready = (i % 2 == 0);
      tick();
    end
    en = '0; mem_ready = 1'b1;
    repeat (12) tick();
    check("fair_beats", hs_log.size(), 12);
    s0_cnt = 0; s3_cnt = 0;
    for (int j = 0; j < hs_log.size(); j++) begin
      check("fair_order", hs_log[j][11:8], (j % 2 == 0) ? 1 : 3);
      if (hs_log[j][11:8] == 4'h1) s0_cnt++;
      if (hs_log[j][11:8] == 4'h3) s3_cnt++;
    end
    check("fair_s0", s0_cnt, 6);
    check("fair_s3", s3_cnt, 6);
    check("fair_overflow", overflow, 4'b1001);

    // Backpressure: output stalled on a stream-0 beat while stream 1 overfills
    do_reset();
    mem_ready = 1'b0;
    drive(0, 16'h000A, {16{8'h3C}});
    tick(); en = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1, 16'(16'h0050 + i), {16{8'(8'hC0 + i)}});
      tick();
      check("stall_en", mem_wr_en, 1);
      check("stall_addr", mem_wr_addr, 16'h000A);
      check("stall_data", mem_wr_data, {16{8'h3C}});
    end
    en = '0;
    repeat (3) tick();
    check("bp_overflow", overflow, 4'b0010);
    hs_log.delete();
    mem_ready = 1'b1;
    repeat (7) tick();
    check("bp_beats", hs_log.size(), 5);
    if (hs_log.size() == 5) begin
      check("bp_first", hs_log[0], 16'h000A);
      for (int j = 1; j < 5; j++) check("bp_order", hs_log[j], 16'(16'h004F + j));
    end

    // Done pulse after the 6th handshake, none after the 7th
    do_reset();
    cfg = 16'd6; start = 1'b1;
    tick(); start = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(0, 16'(16'h0600 + i), {16{8'(8'h60 + i)}});
      tick();
    end
    en = '0;
    tick();
    check("done_early", done, 0);
    check("count5", write_count, 5);
    tick();
    check("done_pulse", done, 1);
    check("count6", write_count, 6);
    tick();
    check("done_drop", done, 0);
    drive(0, 16'h0606, {16{8'h66}});
    tick(); en = '0;
    repeat (3) tick();
    check("count7", write_count, 7);
    check("done_once", done_cnt, 1);
    // start coinciding with a handshake: count goes to 0
    drive(0, 16'h0700, {16{8'h70}});
    tick(); en = '0;
    tick();
    start = 1'b1;
    tick(); start = 1'b0;
    check("start_wins", write_count, 0);

    // Reset with beats in flight
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2, 16'(16'h0800 + i), {16{8'(8'h90 + i)}});
      tick();
    end
    en = '0;
    tick();
    check("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_en", mem_wr_en, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", mem_wr_addr, 0);
    check("mid_rst_data", mem_wr_data, 0);
    check("mid_rst_count", write_count, 0);
    tick();
    rst_n = 1'b1; mem_ready = 1'b1;
    drive(1, 16'h0900, {16{8'h99}});
    tick(); en = '0;
    check("post_rst_t1", mem_wr_en, 0);
    tick();
    check("post_rst_t2", mem_wr_en, 1);
    check("post_rst_addr", mem_wr_addr, 16'h0900);
    repeat (3) tick();
    check("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/quant_wr_merge_4to1.md
Name: quant_wr_merge_4to1

Overview:
- Downstream of the 4-row quantise/write stage.
- Accepts its four independent, non-backpressured write streams (one per output-row offset, each with en/addr/data) and buffers each in a small FIFO.
- Round-robin merges them onto the single write port of the output activation SRAM, which supports backpressure.
- Counts committed writes per layer and pulses done when the configured total is reached.

Parameters:
- UNIT_NUM, 16, lanes (channels) per write beat.
- OUT_BITS, 8, bits per lane.
- ADDR_W, 16, SRAM word-address width.
- FIFO_DEPTH, 4, entries per input FIFO. Must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en0..wr_en3  in  1 each  write strobe for stream n. Cannot be stalled.
- wr_addr0..wr_addr3  in  ADDR_W each  word address for stream n.
- wr_data0..wr_data3  in  UNIT_NUM*OUT_BITS each  packed data for stream n.
- start  in  1  one-cycle layer start. Clears write count and overflow flags.
- cfg_expected_writes  in  16  total SRAM writes expected this layer.
- mem_ready  in  1  SRAM accepts the beat this cycle.
- mem_wr_en  out  1  output beat valid.
- mem_wr_addr  out  ADDR_W  output address.
- mem_wr_data  out  UNIT_NUM*OUT_BITS  output data.
- done  out  1  one-cycle pulse when the expected write count is reached.
- busy  out  1  any FIFO non-empty or mem_wr_en high.
- overflow  out  4  sticky per-stream drop flags.
- write_count  out  16  committed writes since the last start.

Behaviour:
- Reset values: every output is 0. FIFOs are empty, RR pointer = 0, write_count = 0.
- Push:
  - wr_enN pushes {addr, data} into FIFO n at the clock edge.
  - If FIFO n is full and is not popped in the same cycle, the beat is dropped and overflow[n] is set. The flag stays set until start or reset.
  - Push and pop on a full FIFO in the same cycle: both take effect, no drop.
- Output register (valid/ready):
  - The register loads when it is empty, or when it holds a beat and mem_ready=1.
  - On load it takes the head of the granted FIFO and pops that FIFO in the same cycle.
  - While mem_wr_en=1 and mem_ready=0, mem_wr_addr and mem_wr_data hold stable and no FIFO pops.
- Arbitration:
  - Round-robin over non-empty FIFOs, searching from the RR pointer upward with wrap 3 to 0.
  - On a grant to stream k, the pointer becomes (k+1) mod 4.
  - If no FIFO is non-empty, the register empties after acceptance and mem_wr_en drops to 0.
- Latency: with the FIFO empty, the output idle and mem_ready=1, wr_enN at cycle t gives mem_wr_en=1 at cycle t+2.
- Throughput: one beat per cycle while mem_ready=1.
- Count:
  - write_count increments on each mem_wr_en&&mem_ready handshake, wrapping at 16 bits.
  - done=1 for exactly the cycle after the handshake that makes write_count equal cfg_expected_writes.
  - If cfg_expected_writes=0, done never fires.
- start:
  - Clears write_count and overflow on the next edge.
  - Does not flush FIFOs or the output register.
  - If a handshake occurs in the same cycle as start, start wins: count becomes 0, not 1.
- Reset mid-operation: all state clears immediately, and in-flight beats are discarded.
- Address and data pass through unmodified. No address range checking is done.

Decomposition:
- Shared package:
  - NUM_STREAMS=4.
  - Beat width constant: ADDR_W+UNIT_NUM*OUT_BITS.
  - Packed beat typedef {addr, data}.
  - RR pointer typedef, 2 bits.
- Sub-module: wr_beat_fifo, a synchronous FIFO with push, pop, full, empty and head, instantiated four times.
- Arbiter and output register live in the top module.

Test Plan:
- Single beat: wr_en2 with addr=0x0010, data=all 0xA5, mem_ready=1 -> mem_wr_en=1 two cycles later with identical addr and data, write_count=1.
- Simultaneous: all four wr_en in one cycle, addrs 0..3, mem_ready=1, after reset -> output order addr 0,1,2,3 on consecutive cycles, busy drops after the last.
- Fairness: streams 0 and 3 pushed every cycle for 8 cycles with mem_ready alternating 1/0 -> grants alternate 0,3,0,3, no stream starves, overflow flags set only where the FIFO actually filled.
- Backpressure: mem_ready=0 for 10 cycles while stream 1 pushes 5 beats (depth 4) -> overflow=4'b0010, 4 beats delivered in order after mem_ready=1, mem_wr_addr/mem_wr_data stable during the stall.
- Done: start, cfg_expected_writes=6, feed 6 beats -> done pulses once one cycle after the 6th handshake. A 7th beat gives no further pulse.
- Reset mid-layer: assert rst_n=0 with 3 beats buffered -> all outputs 0 and FIFOs empty. After release, a new beat emerges with 2-cycle latency.
